fft_output_buffer: RTL
======================

Name: fft_output_buffer

Overview:
Frame buffer on the FFT output side of the audio sensing chain. It captures one frame of NSamples FFT output words from the FFT core's source interface into an on-chip RAM, then drains the frame on a dstream valid/ready source to downstream consumers (magnitude/display logic). Capture is disabled while draining, so frames never interleave. The block runs on the single FFT/system clock domain.

Parameters:
W, 16, sample/bin word width in bits
NSamples, 1024, words per frame; power of two, >= 2; address width AW = $clog2(NSamples)

Ports:
clk  input  1  system/FFT clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
fft_output  input  W  FFT output word
fft_output_valid  input  1  fft_output carries a word this cycle
fft_output_ready  output  1  buffer accepts a word this cycle (combinational, = state==FILL)
out_stream  dstream.out  W+2  data[W-1:0], valid (out), ready (in)
frame_last  output  1  high with valid when the presented word is bin NSamples-1
drop_count  output  8  saturating count of words offered while not ready

Behaviour:
- One clock and one reset for the whole block: single clk domain; reset_n asynchronous, active-low.
- Reset (async assert, sync-safe deassert in integration): state=FILL, wr_idx=0, rd_idx=0, out_stream.valid=0, out_stream.data=0, frame_last=0, drop_count=0; fft_output_ready reads 1 from FILL.
- Storage: NSamples x W single-clock RAM, one write port, one read port with 1-cycle registered read; read data drives out_stream.data.
- FSM states FILL, PRIME, DRAIN.
- FILL: fft_output_ready=1. Each cycle with fft_output_valid=1 writes mem[wr_idx]=fft_output, wr_idx++. Gaps in valid are allowed and hold wr_idx. Writing index NSamples-1 moves to PRIME next cycle, wr_idx wraps to 0.
- PRIME (exactly 1 cycle): ready=0; read address=0. Goes to DRAIN.
- DRAIN: out_stream.valid=1; data=mem[rd_idx]. Read address = (valid&&ready) ? rd_idx+1 : rd_idx, so consecutive handshakes stream with no bubbles. Data and frame_last are held stable while valid && !ready.
- frame_last=1 exactly while rd_idx==NSamples-1 in DRAIN.
- Handshake on rd_idx==NSamples-1: next cycle state=FILL, valid=0, frame_last=0, rd_idx=0.
- Latency: last write at cycle t -> PRIME at t+1 -> first valid with bin 0 at t+2. A downstream stall has no upper bound; the frame is never lost.
- Drops: fft_output_valid=1 while state!=FILL increments drop_count. The counter saturates at 255 and clears only on reset. The offered word is discarded; the frame in RAM is untouched.
- Simultaneous events: the final handshake in DRAIN and fft_output_valid in the same cycle count as a drop, because ready was 0 that cycle. In the next cycle (FILL) the word is accepted.
- Reset mid-operation: a partial fill or drain is discarded. After reset the block restarts in FILL at index 0, with valid low the next edge.
- Frame contents and order: the output order equals the input order (bin 0 first). No reordering or scaling is performed, and the width is passed through unchanged.

Test Plan:
- NSamples=8, W=16: feed 1..8 on consecutive cycles with out_stream.ready=1 -> valid rises 2 cycles after the 8th write; data 1..8 on 8 consecutive cycles; frame_last only with 8; valid low afterwards; drop_count=0.
- Gapped input (valid on alternate cycles, words 0x10..0x17) -> identical output 0x10..0x17; fft_output_ready stays 1 throughout FILL.
- Backpressure: toggle out_stream.ready pseudo-randomly in DRAIN -> every word is delivered exactly once and in order; data and frame_last stay stable during stalls; no bubble after any ready-high cycle.
- Hold fft_output_valid=1 continuously for 300 cycles while the output drains with ready=0 for 290 cycles -> the first 8 words are captured, then the counter saturates at drop_count=255; after the drain the next frame is captured correctly from the following accepted word.
- Final handshake coincident with input valid (word 0xAA) -> drop_count increments by 1; 0xAA is not stored; the next word is stored at index 0.
- Assert reset_n=0 mid-DRAIN (after 3 words) -> valid=0 and drop_count=0 asynchronously; the next full frame of 8 words is output starting at bin 0.

Source files
------------

// File: rtl/fft_output_buffer_if.sv
// ----------------------------------------------------------------------------
// fft_output_buffer_if
//
// Valid/ready stream ("dstream") carrying one W-bit word per handshake.
// A word transfers on any rising clock edge where valid && ready.
//
// Signals:
//   data   [W-1:0]  payload word, driven by the master
//   valid           master presents a word this cycle
//   ready           slave accepts the presented word this cycle
//
// Modports:
//   master  source side (drives data/valid, samples ready)
//   slave   sink side (samples data/valid, drives ready)
// ----------------------------------------------------------------------------
interface fft_output_buffer_if #(
  parameter int unsigned W = 16
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/fft_output_buffer.sv
// ----------------------------------------------------------------------------
// fft_output_buffer
//
// Frame buffer behind the FFT core. Captures one frame of NSamples words from
// the FFT source interface into a single-clock RAM, then drains the frame in
// capture order on a valid/ready stream. Capture is refused while a frame is
// being drained, so frames never interleave; words offered in that window are
// discarded and counted in a saturating drop counter.
//
// Parameters:
//   W         word width in bits
//   NSamples  words per frame (power of two, >= 2)
//
// Ports:
//   clk               system/FFT clock, rising edge
//   reset_n           asynchronous active-low reset
//   fft_output        FFT output word
//   fft_output_valid  fft_output carries a word this cycle
//   fft_output_ready  buffer accepts a word this cycle (high only while filling)
//   out_stream        drain stream: data (registered RAM read), valid, ready
//   frame_last        high with valid while the presented word is bin NSamples-1
//   drop_count        saturating count of words offered while not ready
// ----------------------------------------------------------------------------
module fft_output_buffer #(
  parameter int unsigned W        = 16,
  parameter int unsigned NSamples = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [W-1:0]         fft_output,
  input  logic                 fft_output_valid,
  output logic                 fft_output_ready,
  fft_output_buffer_if.master  out_stream,
  output logic                 frame_last,
  output logic [7:0]           drop_count
);

  localparam int unsigned AW = (NSamples > 1) ? $clog2(NSamples) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(NSamples - 1);

  typedef enum logic [1:0] {
    StFill,
    StPrime,
    StDrain
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [AW-1:0] rd_addr;
  logic [7:0]    drop_q, drop_d;
  logic [W-1:0]  rd_data_q;
  logic          wr_en;
  logic          out_valid;
  logic          out_last;

  logic [W-1:0]  mem [NSamples];

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    wr_idx_d         = wr_idx_q;
    rd_idx_d         = rd_idx_q;
    rd_addr          = rd_idx_q;
    wr_en            = 1'b0;
    fft_output_ready = 1'b0;
    out_valid        = 1'b0;
    out_last         = 1'b0;

    unique case (state_q)
      StFill: begin
        fft_output_ready = 1'b1;
        if (fft_output_valid) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;  // wraps to 0 after the last bin
          if (wr_idx_q == LastIdx) begin
            state_d = StPrime;
          end
        end
      end

      StPrime: begin
        // Launch the read of bin 0 so it is on the bus when valid rises.
        rd_addr  = '0;
        rd_idx_d = '0;
        state_d  = StDrain;
      end

      StDrain: begin
        out_valid = 1'b1;
        out_last  = (rd_idx_q == LastIdx);
        // Prefetch the next bin on a handshake so back-to-back transfers have
        // no bubble; otherwise re-read the same bin, which keeps data stable.
        if (out_stream.ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          rd_addr  = rd_idx_q + 1'b1;
          if (rd_idx_q == LastIdx) begin
            state_d = StFill;
          end
        end
      end

      default: begin
        state_d = StFill;
      end
    endcase
  end

  // Offers outside FILL are discarded; the counter sticks at 255.
  always_comb begin
    drop_d = drop_q;
    if (fft_output_valid && (state_q != StFill) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StFill;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      drop_q   <= drop_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame RAM: one write port, one registered read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx_q] <= fft_output;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_stream.data  = rd_data_q;
  assign out_stream.valid = out_valid;
  assign frame_last       = out_last;
  assign drop_count       = drop_q;

endmodule
